// File: rtl/gtx_2p5g_pkg.sv
// Shared types and helpers for the GTX 2.5G channel reset sequencer.
//   state_e    : per-channel sequencer state (3-bit)
//   SYNC_DEPTH : flop count of the async-input synchronizers
//   clog2/max3 : elaboration-time width helpers
package gtx_2p5g_pkg;

   typedef enum logic [2:0] {
      S_RST       = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RELEASE   = 3'd2,
      S_USERRDY   = 3'd3,
      S_READY     = 3'd4,
      S_FAULT     = 3'd5
   } state_e;

   localparam int unsigned SYNC_DEPTH = 2;

   // Bits needed to hold values 0..value-1, never less than one.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((64'd1 << width) < 64'(value)) width++;
      return (width == 0) ? 1 : width;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/gtx_2p5g_chnl_rst_seq_if.sv
// GT-side signal bundle between the reset sequencer and the GTX channels.
//   pll_lock, tx_resetdone, rx_resetdone : status from the channels (async)
//   gt_txreset, gt_rxreset               : channel resets
//   txuserrdy, rxuserrdy                 : user-clock-ready strobes
// master = sequencer side, slave = transceiver side.
interface gtx_2p5g_chnl_rst_seq_if #(
   parameter int unsigned CHNL_NUM = 8
);

   logic [CHNL_NUM-1:0] pll_lock;
   logic [CHNL_NUM-1:0] tx_resetdone;
   logic [CHNL_NUM-1:0] rx_resetdone;
   logic [CHNL_NUM-1:0] gt_txreset;
   logic [CHNL_NUM-1:0] gt_rxreset;
   logic [CHNL_NUM-1:0] txuserrdy;
   logic [CHNL_NUM-1:0] rxuserrdy;

   modport master (
      input  pll_lock, tx_resetdone, rx_resetdone,
      output gt_txreset, gt_rxreset, txuserrdy, rxuserrdy
   );

   modport slave (
      output pll_lock, tx_resetdone, rx_resetdone,
      input  gt_txreset, gt_rxreset, txuserrdy, rxuserrdy
   );

endinterface

// File: rtl/gtx_2p5g_rst_seq_fsm.sv
// One-channel reset/user-ready sequencer.
//   sys_clk, rst_n     : system clock, async active-low reset
//   soft_reset         : level restart request (sys_clk domain)
//   pll_lock           : PLL lock, async, synchronized here
//   tx/rx_resetdone    : GT reset-done, async, synchronized here
//   gt_tx/rxreset      : GT resets (registered)
//   tx/rxuserrdy       : GT user-ready (registered)
//   chnl_ready         : channel up
//   chnl_fault         : retries exhausted, waiting for soft_reset
//   retry_cnt          : number of reset-done timeouts seen
module gtx_2p5g_rst_seq_fsm
   import gtx_2p5g_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYC     = 16,
   parameter int unsigned USRCLK_WAIT_CYC  = 1024,
   parameter int unsigned DONE_TIMEOUT_CYC = 65536,
   parameter int unsigned MAX_RETRY        = 7,
   localparam int unsigned RW = clog2(MAX_RETRY + 1)
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   input  logic          soft_reset,
   input  logic          pll_lock,
   input  logic          tx_resetdone,
   input  logic          rx_resetdone,
   output logic          gt_txreset,
   output logic          gt_rxreset,
   output logic          txuserrdy,
   output logic          rxuserrdy,
   output logic          chnl_ready,
   output logic          chnl_fault,
   output logic [RW-1:0] retry_cnt
);

   localparam int unsigned CW =
      clog2(max3(RST_HOLD_CYC, USRCLK_WAIT_CYC, DONE_TIMEOUT_CYC) + 1);

   // A state with terminal count N is left on its N-th cycle.
   localparam logic [CW-1:0] RST_TC  = CW'(RST_HOLD_CYC - 1);
   localparam logic [CW-1:0] USR_TC  = CW'(USRCLK_WAIT_CYC - 1);
   localparam logic [CW-1:0] DONE_TC = CW'(DONE_TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   logic [SYNC_DEPTH-1:0] lock_sync_q, txdone_sync_q, rxdone_sync_q;
   logic                  lock_s, done_s;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          resets_d, userrdy_d;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_sync_q   <= '0;
         txdone_sync_q <= '0;
         rxdone_sync_q <= '0;
      end else begin
         lock_sync_q   <= {lock_sync_q[SYNC_DEPTH-2:0], pll_lock};
         txdone_sync_q <= {txdone_sync_q[SYNC_DEPTH-2:0], tx_resetdone};
         rxdone_sync_q <= {rxdone_sync_q[SYNC_DEPTH-2:0], rx_resetdone};
      end
   end

   assign lock_s = lock_sync_q[SYNC_DEPTH-1];
   assign done_s = txdone_sync_q[SYNC_DEPTH-1] & rxdone_sync_q[SYNC_DEPTH-1];

   // Priority: soft_reset > pll loss > timeout > reset-done success.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if (soft_reset) begin
         state_d = S_RST;
         retry_d = '0;
      end else begin
         case (state_q)
            S_RST:       if (cnt_q == RST_TC) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: if (lock_s) state_d = S_RELEASE;
            S_RELEASE: begin
               if (!lock_s)               state_d = S_RST;
               else if (cnt_q == USR_TC)  state_d = S_USERRDY;
            end
            S_USERRDY: begin
               if (!lock_s) begin
                  state_d = S_RST;
               end else if (cnt_q == DONE_TC) begin
                  // Done arriving on the terminal cycle is still a timeout.
                  if (retry_q == RETRY_MAX) begin
                     state_d = S_FAULT;
                  end else begin
                     retry_d = retry_q + 1'b1;
                     state_d = S_RST;
                  end
               end else if (done_s) begin
                  state_d = S_READY;
               end
            end
            S_READY:     if (!lock_s || !done_s) state_d = S_RST;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_RST;
         endcase
      end

      // Held soft_reset keeps the counter at zero so S_RST restarts its hold.
      if (soft_reset || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q == '1) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      resets_d  = (state_d == S_RST) || (state_d == S_WAIT_LOCK) || (state_d == S_FAULT);
      userrdy_d = (state_d == S_USERRDY) || (state_d == S_READY);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RST;
         cnt_q      <= '0;
         retry_q    <= '0;
         gt_txreset <= 1'b1;
         gt_rxreset <= 1'b1;
         txuserrdy  <= 1'b0;
         rxuserrdy  <= 1'b0;
         chnl_ready <= 1'b0;
         chnl_fault <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         gt_txreset <= resets_d;
         gt_rxreset <= resets_d;
         txuserrdy  <= userrdy_d;
         rxuserrdy  <= userrdy_d;
         chnl_ready <= (state_d == S_READY);
         chnl_fault <= (state_d == S_FAULT);
      end
   end

   assign retry_cnt = retry_q;

endmodule

// File: rtl/gtx_2p5g_chnl_rst_seq.sv
// Multi-channel GTX 2.5G reset/user-ready sequencer.
//   sys_clk, rst_n : free-running system clock, async active-low reset
//   soft_reset     : per-channel restart request
//   gt             : GT-side bundle (lock/resetdone in, resets/userrdy out)
//   chnl_ready     : per-channel up
//   chnl_fault     : per-channel retries exhausted
//   retry_cnt      : per-channel timeout count, channel n at [n*RW +: RW]
//   all_ready      : registered AND of chnl_ready
module gtx_2p5g_chnl_rst_seq
   import gtx_2p5g_pkg::*;
#(
   parameter int unsigned CHNL_NUM         = 8,
   parameter int unsigned RST_HOLD_CYC     = 16,
   parameter int unsigned USRCLK_WAIT_CYC  = 1024,
   parameter int unsigned DONE_TIMEOUT_CYC = 65536,
   parameter int unsigned MAX_RETRY        = 7,
   localparam int unsigned RW = clog2(MAX_RETRY + 1)
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic [CHNL_NUM-1:0]    soft_reset,
   gtx_2p5g_chnl_rst_seq_if.master gt,
   output logic [CHNL_NUM-1:0]    chnl_ready,
   output logic [CHNL_NUM-1:0]    chnl_fault,
   output logic [CHNL_NUM*RW-1:0] retry_cnt,
   output logic                   all_ready
);

   logic [CHNL_NUM-1:0] txreset_v, rxreset_v, txuserrdy_v, rxuserrdy_v;

   for (genvar i = 0; i < CHNL_NUM; i++) begin : g_chnl
      gtx_2p5g_rst_seq_fsm #(
         .RST_HOLD_CYC     (RST_HOLD_CYC),
         .USRCLK_WAIT_CYC  (USRCLK_WAIT_CYC),
         .DONE_TIMEOUT_CYC (DONE_TIMEOUT_CYC),
         .MAX_RETRY        (MAX_RETRY)
      ) u_fsm (
         .sys_clk      (sys_clk),
         .rst_n        (rst_n),
         .soft_reset   (soft_reset[i]),
         .pll_lock     (gt.pll_lock[i]),
         .tx_resetdone (gt.tx_resetdone[i]),
         .rx_resetdone (gt.rx_resetdone[i]),
         .gt_txreset   (txreset_v[i]),
         .gt_rxreset   (rxreset_v[i]),
         .txuserrdy    (txuserrdy_v[i]),
         .rxuserrdy    (rxuserrdy_v[i]),
         .chnl_ready   (chnl_ready[i]),
         .chnl_fault   (chnl_fault[i]),
         .retry_cnt    (retry_cnt[i*RW +: RW])
      );
   end

   assign gt.gt_txreset = txreset_v;
   assign gt.gt_rxreset = rxreset_v;
   assign gt.txuserrdy  = txuserrdy_v;
   assign gt.rxuserrdy  = rxuserrdy_v;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         all_ready <= 1'b0;
      end else begin
         all_ready <= &chnl_ready;
      end
   end

endmodule

// File: tb/tb_gtx_2p5g_chnl_rst_seq.sv
// Self-checking bench for gtx_2p5g_chnl_rst_seq: directed bring-up/fault scenarios
// followed by a randomized soak, all checked each cycle against a phase/timer model.
module tb_gtx_2p5g_chnl_rst_seq;

   localparam int N  = 2;
   localparam int RH = 4;
   localparam int UW = 8;
   localparam int DT = 32;
   localparam int MR = 2;
   localparam int RW = 2;

   localparam int P_RST = 0, P_WAIT = 1, P_REL = 2, P_URDY = 3, P_READY = 4, P_FAULT = 5;
   localparam int SEL_TXRST = 0, SEL_URDY = 1, SEL_READY = 2, SEL_FAULT = 3, SEL_ALL = 4,
                  SEL_RETRY = 5;

   logic          sys_clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  soft_reset = '0;
   logic [N-1:0]  chnl_ready, chnl_fault;
   logic [N*RW-1:0] retry_cnt;
   logic          all_ready;

   gtx_2p5g_chnl_rst_seq_if #(.CHNL_NUM(N)) gt_if ();

   gtx_2p5g_chnl_rst_seq #(
      .CHNL_NUM         (N),
      .RST_HOLD_CYC     (RH),
      .USRCLK_WAIT_CYC  (UW),
      .DONE_TIMEOUT_CYC (DT),
      .MAX_RETRY        (MR)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .soft_reset (soft_reset),
      .gt         (gt_if),
      .chnl_ready (chnl_ready),
      .chnl_fault (chnl_fault),
      .retry_cnt  (retry_cnt),
      .all_ready  (all_ready)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int ch, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", name, ch, act, exp, $time);
      end
   endtask

   // ---------------- GT emulator: resetdone follows userrdy after a delay ----------------
   logic [N-1:0] done_en = '1;
   int done_dly[N] = '{10, 10};
   int rx_skew[N]  = '{0, 0};
   int ucnt[N]     = '{0, 0};

   initial forever begin
      @(negedge sys_clk);
      for (int c = 0; c < N; c++) begin
         if (!rst_n || gt_if.gt_txreset[c]) ucnt[c] = 0;
         else if (gt_if.txuserrdy[c] && ucnt[c] < 1000) ucnt[c]++;
         gt_if.tx_resetdone[c] = done_en[c] && (ucnt[c] >= done_dly[c]);
         gt_if.rx_resetdone[c] = done_en[c] && (ucnt[c] >= done_dly[c] + rx_skew[c]);
      end
   end

   // ---------------- Reference model: phase + time-in-phase per channel ----------------
   int   m_ph[N], m_t[N], m_retry[N];
   logic [N-1:0] m_l1, m_l2, m_tx1, m_tx2, m_rx1, m_rx2;
   logic m_all;

   initial forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) begin
         for (int c = 0; c < N; c++) begin
            m_ph[c] = P_RST; m_t[c] = 0; m_retry[c] = 0;
         end
         m_l1 = '0; m_l2 = '0; m_tx1 = '0; m_tx2 = '0; m_rx1 = '0; m_rx2 = '0;
         m_all = 1'b0;
      end else begin
         logic all_now;
         all_now = 1'b1;
         for (int c = 0; c < N; c++) all_now &= (m_ph[c] == P_READY);
         for (int c = 0; c < N; c++) begin
            logic ls, ds;
            int   nxt, spent;
            bit   restart;
            // inputs as seen two sys_clk edges ago
            ls = m_l2[c];
            ds = m_tx2[c] & m_rx2[c];
            m_l2[c] = m_l1[c];  m_l1[c] = gt_if.pll_lock[c];
            m_tx2[c] = m_tx1[c]; m_tx1[c] = gt_if.tx_resetdone[c];
            m_rx2[c] = m_rx1[c]; m_rx1[c] = gt_if.rx_resetdone[c];
            nxt = m_ph[c];
            spent = m_t[c] + 1;
            restart = 0;
            if (soft_reset[c]) begin
               nxt = P_RST; m_retry[c] = 0; restart = 1;
            end else begin
               case (m_ph[c])
                  P_RST:   if (spent >= RH) nxt = P_WAIT;
                  P_WAIT:  if (ls) nxt = P_REL;
                  P_REL:   if (!ls) nxt = P_RST; else if (spent >= UW) nxt = P_URDY;
                  P_URDY: begin
                     if (!ls) nxt = P_RST;
                     else if (spent >= DT) begin
                        if (m_retry[c] + 1 > MR) nxt = P_FAULT;
                        else begin m_retry[c]++; nxt = P_RST; end
                     end else if (ds) nxt = P_READY;
                  end
                  P_READY: if (!ls || !ds) nxt = P_RST;
                  default: ;
               endcase
            end
            m_t[c] = (restart || nxt != m_ph[c]) ? 0 : spent;
            m_ph[c] = nxt;
         end
         m_all = all_now;
      end
   end

   // ---------------- Per-cycle compare ----------------
   initial forever begin
      @(negedge sys_clk);
      for (int c = 0; c < N; c++) begin
         logic er, eu;
         er = (m_ph[c] == P_RST) || (m_ph[c] == P_WAIT) || (m_ph[c] == P_FAULT);
         eu = (m_ph[c] == P_URDY) || (m_ph[c] == P_READY);
         check("gt_txreset", c, gt_if.gt_txreset[c], er);
         check("gt_rxreset", c, gt_if.gt_rxreset[c], er);
         check("txuserrdy", c, gt_if.txuserrdy[c], eu);
         check("rxuserrdy", c, gt_if.rxuserrdy[c], eu);
         check("chnl_ready", c, chnl_ready[c], m_ph[c] == P_READY);
         check("chnl_fault", c, chnl_fault[c], m_ph[c] == P_FAULT);
         check("retry_cnt", c, retry_cnt[c*RW +: RW], m_retry[c]);
      end
      check("all_ready", 0, all_ready, m_all);
   end

   // ---------------- Scenario helpers ----------------
   function automatic int get(input int sel, input int ch);
      case (sel)
         SEL_TXRST: return int'(gt_if.gt_txreset[ch]);
         SEL_URDY:  return int'(gt_if.txuserrdy[ch]);
         SEL_READY: return int'(chnl_ready[ch]);
         SEL_FAULT: return int'(chnl_fault[ch]);
         SEL_ALL:   return int'(all_ready);
         default:   return int'(retry_cnt[ch*RW +: RW]);
      endcase
   endfunction

   task automatic wait_for(input string name, input int sel, input int ch, input int val,
                           input int budget, output int n);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (get(sel, ch) != val && n < budget);
      vectors++;
      if (get(sel, ch) != val) begin
         miscompares++;
         $display("FAIL %s ch%0d: value %0d after %0d cycles, waited for %0d",
                  name, ch, get(sel, ch), n, val);
      end
   endtask

   task automatic pulse_soft(input int ch);
      soft_reset[ch] = 1'b1;
      @(negedge sys_clk);
      soft_reset[ch] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      miscompares++;
      $display("FAIL watchdog: bench did not complete in time");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // ---------------- Directed scenarios then random soak ----------------
   initial begin
      int n;
      gt_if.pll_lock = '1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("rst_txreset", 0, gt_if.gt_txreset, 2'b11);
      check("rst_userrdy", 0, gt_if.txuserrdy, 2'b00);
      check("rst_retry", 0, retry_cnt, 0);

      // 1. bring-up
      rst_n = 1'b1;
      wait_for("t1_reset_fall", SEL_TXRST, 0, 0, 50, n);  check("t1_reset_lat", 0, n, 5);
      wait_for("t1_userrdy", SEL_URDY, 0, 1, 50, n);      check("t1_userrdy_lat", 0, n, 8);
      wait_for("t1_ready", SEL_READY, 0, 1, 50, n);       check("t1_ready_lat", 0, n, 12);
      wait_for("t1_all", SEL_ALL, 0, 1, 10, n);           check("t1_all_lat", 0, n, 1);

      // 4. lock loss in ready on ch0
      gt_if.pll_lock[0] = 1'b0;
      wait_for("t4_unready", SEL_READY, 0, 0, 10, n);     check("t4_loss_lat", 0, n, 3);
      check("t4_reset", 0, gt_if.gt_txreset[0], 1);
      check("t4_ch1_ready", 1, chnl_ready[1], 1);
      check("t4_retry", 0, retry_cnt, 0);

      // 2. late lock
      repeat (100) @(negedge sys_clk);
      check("t2_reset_held", 0, gt_if.gt_txreset[0], 1);
      gt_if.pll_lock[0] = 1'b1;
      wait_for("t2_reset_fall", SEL_TXRST, 0, 0, 10, n);  check("t2_lock_lat", 0, n, 3);
      wait_for("t2_ready", SEL_READY, 0, 1, 60, n);       check("t2_ready_lat", 0, n, 20);

      // 3. timeouts to fault on ch1
      done_en[1] = 1'b0;
      pulse_soft(1);
      wait_for("t3_retry1", SEL_RETRY, 1, 1, 100, n);     check("t3_retry1_lat", 1, n, 45);
      wait_for("t3_retry2", SEL_RETRY, 1, 2, 100, n);     check("t3_retry2_lat", 1, n, 45);
      wait_for("t3_fault", SEL_FAULT, 1, 1, 100, n);      check("t3_fault_lat", 1, n, 45);
      check("t3_retry_sat", 1, retry_cnt[RW +: RW], 2);
      check("t3_resets", 1, {gt_if.gt_txreset[1], gt_if.gt_rxreset[1]}, 2'b11);
      repeat (50) @(negedge sys_clk);
      check("t3_fault_hold", 1, chnl_fault[1], 1);

      // 5. fault recovery
      done_en[1] = 1'b1;
      pulse_soft(1);
      check("t5_retry_clr", 1, retry_cnt[RW +: RW], 0);
      check("t5_fault_clr", 1, chnl_fault[1], 0);
      wait_for("t5_ready", SEL_READY, 1, 1, 100, n);      check("t5_ready_lat", 1, n, 25);

      // 6. async reset mid-userrdy
      pulse_soft(0);
      wait_for("t6_userrdy", SEL_URDY, 0, 1, 50, n);
      #2 rst_n = 1'b0;
      #1;
      check("t6_txreset", 0, gt_if.gt_txreset, 2'b11);
      check("t6_rxreset", 0, gt_if.gt_rxreset, 2'b11);
      check("t6_userrdy", 0, {gt_if.txuserrdy, gt_if.rxuserrdy}, 0);
      check("t6_ready", 0, {chnl_ready, all_ready}, 0);
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b1;
      wait_for("t6_userrdy2", SEL_URDY, 0, 1, 50, n);     check("t6_userrdy_lat", 0, n, 13);

      // random soak
      for (int i = 0; i < 3000; i++) begin
         @(negedge sys_clk);
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 299) == 0) gt_if.pll_lock[c] = ~gt_if.pll_lock[c];
            soft_reset[c] = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) done_en[c] = ~done_en[c];
            if ($urandom_range(0, 99) == 0) begin
               done_dly[c] = $urandom_range(1, 40);
               rx_skew[c]  = $urandom_range(0, 3);
            end
         end
      end

      // converge both channels to ready
      for (int c = 0; c < N; c++) begin
         done_dly[c] = 10; rx_skew[c] = 0;
      end
      done_en = '1;
      gt_if.pll_lock = '1;
      soft_reset = '1;
      @(negedge sys_clk);
      soft_reset = '0;
      wait_for("soak_all_ready", SEL_ALL, 0, 1, 300, n);

      repeat (5) @(negedge sys_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
